// File: rtl/drive_sequencer.sv
// Two-wheel drive sequencer: debounces tracker decisions, runs the idle/run/search/halt
// mode FSM and produces soft-start, direction-safe PWM for each wheel (index 0 left, 1 right).
module drive_sequencer #(
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned DUTY_FAST     = 200,
  parameter int unsigned DUTY_SLOW     = 100,
  parameter int unsigned RAMP_STEP     = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SEARCH_W      = 20,
  parameter int unsigned SEARCH_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] track_state,
  input  logic       start,
  input  logic       obstacle,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic       left_dir,
  output logic       right_dir,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {StIdle = 2'b00, StRun = 2'b01, StSearch = 2'b10, StHalt = 2'b11} mode_e;

  localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
  localparam logic [StabW-1:0]    StabMax    = StabW'(STABLE_CYCLES - 1);
  localparam logic [SEARCH_W-1:0] SearchLast = SEARCH_W'(SEARCH_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DutyFast   = PWM_BITS'(DUTY_FAST);
  localparam logic [PWM_BITS-1:0] DutySlow   = PWM_BITS'(DUTY_SLOW);
  localparam logic [PWM_BITS:0]   RampStep   = (PWM_BITS + 1)'(RAMP_STEP);

  mode_e                mode_q, mode_d;
  logic [1:0]           raw_q, cmd_q, cmd_d, last_turn_q, last_turn_d, search_dir_q, search_dir_d;
  logic [StabW-1:0]     stab_q, stab_d;
  logic [SEARCH_W-1:0]  search_cnt_q, search_cnt_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q;
  logic [1:0][PWM_BITS-1:0] duty_q, duty_d, tgt_duty, eff;
  logic [1:0][PWM_BITS:0]   sum;
  logic [1:0]           dir_q, dir_d, tgt_dir, pwm_q, pwm_d;
  logic                 wrap;

  assign wrap = &pwm_cnt_q;

  // stab_q counts edges raw_q has held its value; saturates so cmd tracks a steady input.
  always_comb begin
    stab_d      = '0;
    if (track_state == raw_q) stab_d = (stab_q == StabMax) ? stab_q : stab_q + 1'b1;
    cmd_d       = (stab_q == StabMax) ? raw_q : cmd_q;
    last_turn_d = (cmd_d == 2'b01 || cmd_d == 2'b10) ? cmd_d : last_turn_q;
  end

  always_comb begin
    mode_d       = mode_q;
    search_cnt_d = search_cnt_q;
    search_dir_d = search_dir_q;
    unique case (mode_q)
      StIdle, StHalt: if (start) mode_d = StRun;
      StRun: begin
        if (cmd_q == 2'b00) begin
          mode_d       = StSearch;
          search_cnt_d = '0;
          search_dir_d = last_turn_q;
        end
      end
      StSearch: begin
        if (cmd_q != 2'b00)              mode_d = StRun;
        else if (search_cnt_q == SearchLast) mode_d = StHalt;
        else                             search_cnt_d = search_cnt_q + 1'b1;
      end
      default: mode_d = StIdle;
    endcase
  end

  always_comb begin
    tgt_duty = '0;
    tgt_dir  = dir_q;
    case (mode_q)
      StRun: begin
        unique case (cmd_q)
          2'b11: begin tgt_duty = {DutyFast, DutyFast}; tgt_dir = 2'b11; end
          2'b01: begin tgt_duty = {DutyFast, DutySlow}; tgt_dir = 2'b11; end
          2'b10: begin tgt_duty = {DutySlow, DutyFast}; tgt_dir = 2'b11; end
          // Lasts one cycle on the way into search; hold so the wheels don't dip.
          default: tgt_duty = duty_q;
        endcase
      end
      StSearch: begin
        tgt_duty = {DutySlow, DutySlow};
        tgt_dir  = (search_dir_q == 2'b01) ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    eff   = '0;
    sum   = '0;
    duty_d = duty_q;
    dir_d  = dir_q;
    pwm_d  = '0;
    for (int i = 0; i < 2; i++) begin
      // A pending reversal forces the wheel to zero before dir is allowed to flip.
      eff[i] = (tgt_dir[i] != dir_q[i] || obstacle) ? '0 : tgt_duty[i];
      sum[i] = {1'b0, duty_q[i]} + RampStep;
      if (eff[i] < duty_q[i]) begin
        duty_d[i] = eff[i];
      end else if (wrap && eff[i] > duty_q[i]) begin
        duty_d[i] = (sum[i] > {1'b0, eff[i]}) ? eff[i] : sum[i][PWM_BITS-1:0];
      end
      if (wrap && tgt_dir[i] != dir_q[i] && duty_q[i] == '0) dir_d[i] = tgt_dir[i];
      pwm_d[i] = (pwm_cnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q       <= StIdle;
      raw_q        <= 2'b00;
      cmd_q        <= 2'b00;
      stab_q       <= '0;
      last_turn_q  <= 2'b01;
      search_dir_q <= 2'b01;
      search_cnt_q <= '0;
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      dir_q        <= 2'b11;
      pwm_q        <= '0;
    end else begin
      mode_q       <= mode_d;
      raw_q        <= track_state;
      cmd_q        <= cmd_d;
      stab_q       <= stab_d;
      last_turn_q  <= last_turn_d;
      search_dir_q <= search_dir_d;
      search_cnt_q <= search_cnt_d;
      pwm_cnt_q    <= pwm_cnt_q + 1'b1;
      duty_q       <= duty_d;
      dir_q        <= dir_d;
      pwm_q        <= pwm_d;
    end
  end

  assign left_pwm  = pwm_q[0];
  assign right_pwm = pwm_q[1];
  assign left_dir  = dir_q[0];
  assign right_dir = dir_q[1];
  assign mode      = mode_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: directed scenarios plus random track/start/obstacle/reset traffic,
// every cycle compared against a behavioural model of the car's modes, duties and directions.
module tb_drive_sequencer;

  localparam int Fast = 200;
  localparam int Slow = 100;
  localparam int Step = 4;
  localparam int SearchCycles = 100;
  localparam int Period = 256;

  logic       clk, reset, start, obstacle;
  logic [1:0] track_state, mode;
  logic       left_pwm, right_pwm, left_dir, right_dir;

  int n_checks = 0;
  int n_errors = 0;

  drive_sequencer #(
    .PWM_BITS(8), .DUTY_FAST(Fast), .DUTY_SLOW(Slow), .RAMP_STEP(Step),
    .STABLE_CYCLES(4), .SEARCH_W(20), .SEARCH_CYCLES(SearchCycles)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .track_state(track_state),
    .start      (start),
    .obstacle   (obstacle),
    .left_pwm   (left_pwm),
    .right_pwm  (right_pwm),
    .left_dir   (left_dir),
    .right_dir  (right_dir),
    .mode       (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: modes 0 idle, 1 run, 2 search, 3 halt; wheel 0 left, 1 right.
  int m_mode, m_cmd, m_last, m_sdir, m_scnt, m_cnt;
  int m_duty[2], m_dir[2], m_pwm[2];
  int hist[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_cmd = 0; m_last = 1; m_sdir = 1; m_scnt = 0; m_cnt = 0;
    for (int w = 0; w < 2; w++) begin
      m_duty[w] = 0; m_dir[w] = 1; m_pwm[w] = 0;
    end
    hist.delete();
    hist.push_back(0);
  endfunction

  function automatic void model_step(input int ts, input int st, input int ob);
    int n_cmd, n_mode, n_scnt, n_sdir;
    int tdut[2], tdir[2];
    int want, nd[2], ndir[2], npwm[2];
    bit wrap;
    n_cmd = m_cmd;
    // Accept a value once the four most recent samples agree.
    if (hist.size() == 4 && hist[0] == hist[1] && hist[1] == hist[2] && hist[2] == hist[3])
      n_cmd = hist[3];
    hist.push_back(ts);
    if (hist.size() > 4) void'(hist.pop_front());

    n_mode = m_mode; n_scnt = m_scnt; n_sdir = m_sdir;
    if ((m_mode == 0 || m_mode == 3) && st != 0) n_mode = 1;
    else if (m_mode == 1 && m_cmd == 0) begin
      n_mode = 2; n_scnt = 0; n_sdir = m_last;
    end else if (m_mode == 2) begin
      if (m_cmd != 0) n_mode = 1;
      else if (m_scnt == SearchCycles - 1) n_mode = 3;
      else n_scnt = m_scnt + 1;
    end

    for (int w = 0; w < 2; w++) begin
      tdut[w] = 0; tdir[w] = m_dir[w];
    end
    if (m_mode == 1) begin
      case (m_cmd)
        3: begin tdut[0] = Fast; tdut[1] = Fast; tdir[0] = 1; tdir[1] = 1; end
        1: begin tdut[0] = Slow; tdut[1] = Fast; tdir[0] = 1; tdir[1] = 1; end
        2: begin tdut[0] = Fast; tdut[1] = Slow; tdir[0] = 1; tdir[1] = 1; end
        default: begin tdut[0] = m_duty[0]; tdut[1] = m_duty[1]; end
      endcase
    end else if (m_mode == 2) begin
      tdut[0] = Slow; tdut[1] = Slow;
      tdir[0] = (m_sdir == 1) ? 0 : 1;
      tdir[1] = (m_sdir == 1) ? 1 : 0;
    end

    wrap = (m_cnt == Period - 1);
    for (int w = 0; w < 2; w++) begin
      want = (tdir[w] != m_dir[w] || ob != 0) ? 0 : tdut[w];
      nd[w] = m_duty[w];
      if (want < m_duty[w]) nd[w] = want;
      else if (wrap && want > m_duty[w]) nd[w] = (m_duty[w] + Step < want) ? m_duty[w] + Step : want;
      ndir[w] = (wrap && tdir[w] != m_dir[w] && m_duty[w] == 0) ? tdir[w] : m_dir[w];
      npwm[w] = (m_cnt < m_duty[w]) ? 1 : 0;
    end

    m_cmd = n_cmd;
    if (n_cmd == 1 || n_cmd == 2) m_last = n_cmd;
    m_mode = n_mode; m_scnt = n_scnt; m_sdir = n_sdir;
    for (int w = 0; w < 2; w++) begin
      m_duty[w] = nd[w]; m_dir[w] = ndir[w]; m_pwm[w] = npwm[w];
    end
    m_cnt = (m_cnt + 1) % Period;
  endfunction

  task automatic compare_all();
    check_eq("mode", int'(mode), m_mode);
    check_eq("pwm_dir", int'({left_pwm, right_pwm, left_dir, right_dir}),
             m_pwm[0] * 8 + m_pwm[1] * 4 + m_dir[0] * 2 + m_dir[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(int'(track_state), int'(start), int'(obstacle));
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("rst_mode", int'(mode), 0);
    check_eq("rst_pwm", int'({left_pwm, right_pwm}), 0);
    check_eq("rst_dir", int'({left_dir, right_dir}), 3);
    run(n);
    reset = 1'b1;
  endtask

  task automatic count_high(input string tag, input int exp_l, input int exp_r);
    int hl = 0;
    int hr = 0;
    for (int i = 0; i < Period; i++) begin
      tick();
      hl += int'(left_pwm);
      hr += int'(right_pwm);
    end
    check_eq({tag, "_l"}, hl, exp_l);
    check_eq({tag, "_r"}, hr, exp_r);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; obstacle = 1'b0; track_state = 2'b00;
    model_reset();
    #2;
    do_reset(3);

    // Straight run with soft start up to full duty.
    track_state = 2'b11;
    run(6);
    pulse_start();
    check_eq("start_run", int'(mode), 1);
    run(52 * Period);
    count_high("straight", Fast, Fast);
    check_eq("straight_dir", int'({left_dir, right_dir}), 3);

    // Short glitch ignored, held glitch becomes a left turn.
    track_state = 2'b01;
    run(3);
    track_state = 2'b11;
    run(20);
    track_state = 2'b01;
    run(Period + 10);
    count_high("left_turn", Slow, Fast);

    // Right turn, then line lost: search pivot and eventual halt.
    track_state = 2'b10;
    run(30 * Period);
    track_state = 2'b00;
    run(SearchCycles + 40);
    check_eq("halt", int'(mode), 3);

    // Restart, lose the line briefly, recover before timeout.
    pulse_start();
    track_state = 2'b10;
    run(10);
    track_state = 2'b00;
    run(40);
    track_state = 2'b11;
    run(60 * Period);
    count_high("recover", Fast, Fast);

    // Obstacle forces an immediate stop without changing mode.
    obstacle = 1'b1;
    run(2);
    check_eq("obst_pwm", int'({left_pwm, right_pwm}), 0);
    check_eq("obst_mode", int'(mode), 1);
    run(300);
    obstacle = 1'b0;
    run(30 * Period + 100);

    // Reset mid ramp, then no motion without a start pulse.
    do_reset(2);
    track_state = 2'b11;
    run(600);
    check_eq("no_start_mode", int'(mode), 0);
    check_eq("no_start_pwm", int'({left_pwm, right_pwm}), 0);

    // Random traffic.
    for (int k = 0; k < 120; k++) begin
      int len;
      track_state = 2'($urandom_range(0, 3));
      obstacle    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) pulse_start();
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 700);
      run(len);
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
- Sits between the line-tracker decision logic and the two wheel motor drivers.
- Debounces the 2-bit tracker decision and sequences the car through idle, run, lost-line search and halt modes.
- Generates per-wheel PWM with soft-start ramping and safe direction reversal.
- Obstacle input forces an immediate stop.

Parameters:
- PWM_BITS, 8, PWM counter/duty width; PWM period = 2^PWM_BITS clk cycles.
- DUTY_FAST, 200, outer-wheel / straight duty.
- DUTY_SLOW, 100, inner-wheel turn duty and search pivot duty.
- RAMP_STEP, 4, duty increment per PWM period while accelerating.
- STABLE_CYCLES, 4, consecutive identical samples required to accept a new tracker decision.
- SEARCH_W, 20, search counter width.
- SEARCH_CYCLES, 500000, search timeout in clk cycles before halting.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- track_state  input  2  tracker decision: 00 lost/stop, 01 turn left, 10 turn right, 11 straight
- start  input  1  single-cycle pulse; IDLE->RUN, HALT->RUN
- obstacle  input  1  level; forces both duties to 0 while high
- left_pwm  output  1  left motor enable PWM
- right_pwm  output  1  right motor enable PWM
- left_dir  output  1  1 = forward, 0 = reverse
- right_dir  output  1  1 = forward, 0 = reverse
- mode  output  2  00 IDLE, 01 RUN, 10 SEARCH, 11 HALT

Behaviour:
- Reset (reset=0, asynchronous):
  - mode=IDLE; debounced cmd=00; last_turn=01.
  - Both duties 0; pwm outputs 0; dirs 1; all counters 0.
- Debounce:
  - Raw input is registered.
  - cmd updates to raw value once raw has been unchanged for STABLE_CYCLES consecutive clk edges. A raw change at edge t is reflected in cmd at edge t+STABLE_CYCLES.
  - Glitches shorter than STABLE_CYCLES are ignored.
  - last_turn captures cmd whenever cmd becomes 01 or 10.
- FSM:
  - IDLE: start -> RUN.
  - RUN: cmd==00 -> SEARCH; load search counter 0; search_dir = last_turn.
  - SEARCH: cmd!=00 -> RUN. Counter increments each cycle; reaching SEARCH_CYCLES-1 -> HALT.
  - HALT: start -> RUN.
  - start in RUN or SEARCH is ignored. obstacle does not change mode.
- Target per wheel (duty, dir):
  - IDLE or HALT: (0, current dir).
  - RUN, cmd 11: L(FAST,1) R(FAST,1).
  - RUN, cmd 01: L(SLOW,1) R(FAST,1).
  - RUN, cmd 10: L(FAST,1) R(SLOW,1).
  - SEARCH, search_dir 01: L(SLOW,0) R(SLOW,1).
  - SEARCH, search_dir 10: L(SLOW,1) R(SLOW,0).
  - obstacle=1 overrides the target duty to 0 for both wheels.
- PWM:
  - Free-running pwm_cnt of width PWM_BITS; wraps from all-ones to 0.
  - wheel_pwm = (pwm_cnt < duty), registered, 1-cycle latency. duty 0 -> constant 0.
- Duty update (per wheel, independent):
  - Decreases are applied immediately on the next clk edge: duty = target when target < duty, or 0 when obstacle=1.
  - Increases occur only on the pwm_cnt wrap edge: duty = min(duty+RAMP_STEP, target). The sum uses PWM_BITS+1 bits; never overflows.
- Direction change:
  - If target dir != current dir, effective target duty = 0 (snap down).
  - dir flips only on a wrap edge where duty==0.
  - Ramp-up begins on the following wrap edge. A wheel never drives nonzero duty in a stale direction.
- Simultaneous events:
  - Debounced cmd change and search timeout on the same edge: cmd!=00 wins (-> RUN).
  - obstacle and an increase on the same wrap edge: obstacle wins (duty 0).
- Reset mid-operation: all state returns to reset values immediately; PWM outputs drop within the same cycle (asynchronous).

Test Plan:
- Reset release, start pulse, track_state=11 held -> mode=01 after start; duty of both wheels steps 0,4,8..200 on successive wraps (50 periods); pwm high 200 of 256 cycles; dirs 1.
- Running straight at 200, track_state glitches to 01 for 3 cycles -> cmd unchanged, duties remain 200. Held 4 cycles -> left duty drops to 100 on next edge; right stays 200.
- cmd=10, then track_state=00 with SEARCH_CYCLES overridden to 100 -> mode=10. Right duty snaps 0, right_dir flips 1->0 on the next wrap, then ramps to 100; left stays forward at 100. After 100 cycles with no line -> mode=11, both duties 0.
- In SEARCH, track_state=11 restored for 4 cycles -> mode=01 before timeout; reversed wheel goes to 0, flips to forward, ramps to 200.
- obstacle=1 while running at 200 -> both pwm low within 2 cycles; mode stays 01. obstacle=0 -> ramp restarts from 0 in steps of 4.
- reset asserted mid-ramp at duty 120 -> outputs 0, mode=00 immediately. After release, track_state=11 without start -> no motion.
